// File: rtl/rc_sampler_pkg.sv
// Shared state encoding and default widths for the ripple-counter sampler.
package rc_sampler_pkg;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned EXT_W = 16;
   localparam int unsigned WIN_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

endpackage

// File: rtl/rc_sync_filter.sv
// Brings the asynchronous ripple count into the clk domain, drops transient
// codes and reports the per-cycle modular advance of the accepted value.
module rc_sync_filter #(
   parameter int unsigned CNT_W = rc_sampler_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] rc_q,
   output logic [CNT_W-1:0] acc_q,
   output logic [CNT_W-1:0] delta
);

   logic [CNT_W-1:0] sync1;
   logic [CNT_W-1:0] sync2;
   logic [CNT_W-1:0] sync2_d;

   // Two-flop synchroniser, one-cycle history, and a filter that accepts a
   // code only once it has been seen on two consecutive synchronised samples.
   // delta is registered alongside acc_q so both describe the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= '0;
         sync2   <= '0;
         sync2_d <= '0;
         acc_q   <= '0;
         delta   <= '0;
      end else begin
         sync1   <= rc_q;
         sync2   <= sync1;
         sync2_d <= sync2;
         if (sync2 == sync2_d) begin
            acc_q <= sync2;
            delta <= CNT_W'(sync2 - acc_q);
         end else begin
            delta <= '0;
         end
      end
   end

endmodule

// File: rtl/rc_count_sampler.sv
// Gated event counter for a ripple-counted source: measures the number of
// counter advances over a programmable window and hands the result over
// through a valid/ready handshake.
module rc_count_sampler #(
   parameter int unsigned CNT_W = rc_sampler_pkg::CNT_W,
   parameter int unsigned EXT_W = rc_sampler_pkg::EXT_W,
   parameter int unsigned WIN_W = rc_sampler_pkg::WIN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] rc_q,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   output logic             busy,
   output logic [EXT_W-1:0] cnt_out,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             overflow
);

   import rc_sampler_pkg::state_t;
   import rc_sampler_pkg::IDLE;
   import rc_sampler_pkg::ARM;
   import rc_sampler_pkg::MEASURE;
   import rc_sampler_pkg::HOLD;

   localparam int unsigned SUM_W = EXT_W + 1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] acc_q;
   logic [CNT_W-1:0] delta;
   logic [CNT_W-1:0] baseline;
   logic [WIN_W-1:0] win_lat;
   logic [WIN_W-1:0] win_cnt;
   logic [EXT_W-1:0] accum;
   logic [CNT_W-1:0] inc_c;
   logic [SUM_W-1:0] sum_c;
   logic             sat_c;
   logic [EXT_W-1:0] acc_sat_c;
   logic             last_c;

   rc_sync_filter #(
      .CNT_W (CNT_W)
   ) u_sync_filter (
      .clk   (clk),
      .reset (reset),
      .rc_q  (rc_q),
      .acc_q (acc_q),
      .delta (delta)
   );

   // Saturating accumulate: only movement of acc_q relative to the value
   // captured in the previous ARM/MEASURE cycle is counted.
   always_comb begin
      inc_c     = (acc_q != baseline) ? delta : '0;
      sum_c     = SUM_W'(accum) + SUM_W'(inc_c);
      sat_c     = sum_c[EXT_W];
      acc_sat_c = sat_c ? '1 : sum_c[EXT_W-1:0];
      last_c    = (win_cnt == WIN_W'(1));
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is only honoured in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ARM;
         ARM:     state_nxt = (win_lat == '0) ? HOLD : MEASURE;
         MEASURE: if (last_c) state_nxt = HOLD;
         HOLD:    if (cnt_valid && cnt_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Window datapath and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy      <= 1'b0;
         cnt_valid <= 1'b0;
         overflow  <= 1'b0;
         cnt_out   <= '0;
         accum     <= '0;
         baseline  <= '0;
         win_lat   <= '0;
         win_cnt   <= '0;
      end else begin
         busy      <= (state_nxt != IDLE);
         cnt_valid <= (state_nxt == HOLD);
         case (state)
            IDLE: begin
               if (start) win_lat <= win_len;
            end
            ARM: begin
               baseline <= acc_q;
               accum    <= '0;
               win_cnt  <= win_lat;
               if (win_lat == '0) cnt_out <= '0;
            end
            MEASURE: begin
               baseline <= acc_q;
               accum    <= acc_sat_c;
               win_cnt  <= win_cnt - WIN_W'(1);
               if (sat_c)  overflow <= 1'b1;
               if (last_c) cnt_out  <= acc_sat_c;
            end
            HOLD: begin
               if (cnt_valid && cnt_ready) overflow <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
